pattern_player: RTL and testbench
=================================

# pattern_player

Plays the stored game pattern back to the player one bit at a time before the guess phase. Sits between the pattern shift register (source of the 32-bit pattern) and the input handler: the classic-mode FSM starts it after pattern generation, and its `done` pulse is the cue to enable input capture. Each bit is shown for a fixed number of on-cycles followed by a blank gap. Bits play MSB-of-window first: `pattern[length-1]` down to `pattern[0]`, matching the order in which the player re-enters them.

## Interface
- `PATTERN_W`, 32, pattern width in bits
- `LEN_W`, 16, width of the `length` input (the score counter width)
- `ON_CYCLES`, 4, cycles each bit is shown (≥1)
- `OFF_CYCLES`, 2, blank cycles after each bit (≥1)

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin playback; sampled only in IDLE
- `clr`  in  1  synchronous abort to IDLE, priority over `start`
- `pattern`  in  PATTERN_W  pattern to play, latched on accepted `start`
- `length`  in  LEN_W  number of bits to play, latched on accepted `start`
- `led_valid`  out  1  high while a bit is being shown
- `led_bit`  out  1  value of bit currently shown; 0 when `led_valid`=0
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when playback completes

## Operation
- States: IDLE, SHOW, GAP, DONE.
- IDLE: `start`=1 and `clr`=0 → latch `pattern`, latch `eff_len`=min(`length`, PATTERN_W). Set index=`eff_len`-1. If `eff_len`=0 → DONE, else → SHOW with timer=ON_CYCLES-1.
- SHOW: `led_valid`=1, `led_bit`=latched_pattern[index]. When timer=0 → GAP with timer=OFF_CYCLES-1; else decrement timer.
- GAP: outputs low. When timer=0: if index=0 → DONE; else index-1 → SHOW with timer=ON_CYCLES-1.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `clr`=1 in any state → IDLE next edge; `done` is not pulsed. Index and timer are cleared.
- `start` outside IDLE is ignored. Changes to `pattern` or `length` after acceptance have no effect.
- Clamping: `length` > PATTERN_W plays PATTERN_W bits; no wrap of the index.
- Index width is $clog2(PATTERN_W). The timer is wide enough for max(ON_CYCLES, OFF_CYCLES)-1.

## Timing
- Reset values: state IDLE; `led_valid`, `led_bit`, `busy`, `done` all 0. Latched pattern, index and timer are 0.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs.
- Let `start` be accepted at edge 0 and P = ON_CYCLES + OFF_CYCLES.
  - Bit k (k=0 is first played) has `led_valid`=1 in cycles 1+k·P … k·P+ON_CYCLES.
  - The gap follows for OFF_CYCLES cycles.
  - `done`=1 in cycle 1+L·P, where L=`eff_len`.
  - `busy`=1 in cycles 1 … 1+L·P.
- L=0: `done` in cycle 1, `busy` high for that cycle only.
- `start` held high continuously: the next playback is accepted on the first cycle back in IDLE, i.e. the cycle after `done`.
- Asynchronous reset mid-playback: outputs drop immediately and state is IDLE.

## Structure
- Shared package `mem_pkg`:
  - `player_state_t` enum {IDLE, SHOW, GAP, DONE}
  - `PATTERN_W` and `LEN_W` defaults, shared with the shift register, counter and input handler.
- One sub-module, `phase_timer`:
  - loadable down-counter with ports `clk`, `rst_n`, `load`, `load_val`, `zero`.
  - Used for both the SHOW and GAP phases.
- Top: FSM, index register, latched pattern, output decode.

## Test plan
- Reset: assert `rst_n`=0 mid-SHOW → all outputs 0 immediately; after release, state stays IDLE with no `done`.
- Playback: `pattern`=32'h0000_0005, `length`=3, ON=4, OFF=2 → `led_bit` sequence 1,0,1. `led_valid` high in cycles 1–4, 7–10, 13–16; `done` in cycle 19 only.
- Zero length: `length`=0 → no `led_valid`; `done` in cycle 1.
- Clamp: `length`=40, `pattern`=32'h8000_0001 → 32 bits played, first 1, last 1, others 0; `done` in cycle 1+32·6=193.
- Abort and ignore: `clr`=1 during the second bit's GAP → IDLE next cycle with no `done`. Separately, `start` pulsed while busy, with `pattern` changed afterwards → ignored, and the original pattern still plays.
- Back-to-back: `start` held high with `length`=1 → second playback's `led_valid` rises in the cycle after `done`+1; `busy` drops for exactly one cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-game datapath: pattern/length widths
// used by the shift register, score counter, input handler and player.
package mem_pkg;

  localparam int DEF_PATTERN_W = 32;
  localparam int DEF_LEN_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    DONE
  } player_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pattern_player_phase_timer.sv
// Loadable down-counter that times both the SHOW and GAP phases of playback.
// It holds at zero once it gets there, until the next load.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a load wins, otherwise count down and stop at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Plays a latched game pattern to the LEDs one bit at a time, from
// pattern[len-1] down to pattern[0], each bit shown for ON_CYCLES and
// followed by an OFF_CYCLES blank gap. Pulses done when the last gap ends.
module pattern_player
  import mem_pkg::*;
#(
  parameter int PATTERN_W  = DEF_PATTERN_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [LEN_W-1:0]     length,
  output logic                 led_valid,
  output logic                 led_bit,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W   = $clog2(PATTERN_W);
  localparam int TMAX    = max_int(ON_CYCLES, OFF_CYCLES) - 1;
  localparam int TIMER_W = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(PATTERN_W);

  player_state_t        state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic                 led_valid_q, led_valid_d;
  logic                 led_bit_q, led_bit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_val;
  logic                 timer_zero;
  logic [LEN_W-1:0]     eff_len;

  phase_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Next-state logic: phase sequencing, index stepping and the registered
  // outputs for the state being entered, so outputs never see the inputs.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    pat_d      = pat_q;
    timer_load = 1'b0;
    timer_val  = '0;
    eff_len    = (length > LEN_MAX) ? LEN_MAX : length;

    if (clr) begin
      state_d    = IDLE;
      index_d    = '0;
      timer_load = 1'b1;
      timer_val  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_d = pattern;
            if (eff_len == '0) begin
              index_d = '0;
              state_d = DONE;
            end else begin
              index_d    = IDX_W'(eff_len - LEN_W'(1));
              state_d    = SHOW;
              timer_load = 1'b1;
              timer_val  = ON_LOAD;
            end
          end
        end
        SHOW: begin
          if (timer_zero) begin
            state_d    = GAP;
            timer_load = 1'b1;
            timer_val  = OFF_LOAD;
          end
        end
        GAP: begin
          if (timer_zero) begin
            if (index_q == '0) begin
              state_d = DONE;
            end else begin
              index_d    = index_q - IDX_W'(1);
              state_d    = SHOW;
              timer_load = 1'b1;
              timer_val  = ON_LOAD;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    led_valid_d = (state_d == SHOW);
    led_bit_d   = (state_d == SHOW) ? pat_d[index_d] : 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // Playback FSM with latched pattern, bit index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      index_q     <= '0;
      pat_q       <= '0;
      led_valid_q <= 1'b0;
      led_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      pat_q       <= pat_d;
      led_valid_q <= led_valid_d;
      led_bit_q   <= led_bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign led_valid = led_valid_q;
  assign led_bit   = led_bit_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: per-cycle expected LED/busy/done records are
// queued when a playback is started and compared one per clock.
module tb_pattern_player;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [31:0] pattern;
  logic [15:0] length;
  logic        led_valid;
  logic        led_bit;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic v;
    logic b;
    logic bsy;
    logic d;
  } exp_t;

  typedef struct {
    logic [31:0] pat;
    logic [15:0] len;
    int          exp_l;
    int          done_cyc;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   total;
  int   bad;

  pattern_player #(
    .PATTERN_W  (32),
    .LEN_W      (16),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .pattern   (pattern),
    .length    (length),
    .led_valid (led_valid),
    .led_bit   (led_bit),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare the current outputs against one expected record.
  task automatic checkValue(input string name, input exp_t e);
    exp_t got;
    got   = '{v: led_valid, b: led_bit, bsy: busy, d: done};
    total = total + 1;
    if (got !== e) begin
      bad = bad + 1;
      $display("[TB] FAIL %s t=%0t got v/b/busy/done=%b%b%b%b want %b%b%b%b",
               name, $time, got.v, got.b, got.bsy, got.d, e.v, e.b, e.bsy, e.d);
    end
  endtask

  // Advance one clock, sample #1 after the edge, compare against queue head.
  task automatic checkOutput(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL %s scoreboard empty at t=%0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      checkValue(name, e);
    end
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) checkOutput(name);
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{v: 1'b0, b: 1'b0, bsy: 1'b0, d: 1'b0});
  endtask

  // Expected outputs for cycles 1..done_cyc of a playback, then one idle cycle.
  task automatic pushPlay(input logic [31:0] pat, input int l, input int done_cyc);
    int k;
    int ph;
    for (int c = 1; c <= done_cyc; c++) begin
      if (c == done_cyc) begin
        exp_q.push_back('{v: 1'b0, b: 1'b0, bsy: 1'b1, d: 1'b1});
      end else begin
        k  = (c - 1) / P;
        ph = (c - 1) % P;
        if (ph < ON) exp_q.push_back('{v: 1'b1, b: pat[l-1-k], bsy: 1'b1, d: 1'b0});
        else         exp_q.push_back('{v: 1'b0, b: 1'b0, bsy: 1'b1, d: 1'b0});
      end
    end
    pushIdle(1);
  endtask

  // Drive a start request for one cycle and queue the expected playback.
  task automatic applyStimulus(input logic [31:0] pat, input logic [15:0] len,
                               input int l, input int done_cyc);
    pattern = pat;
    length  = len;
    start   = 1'b1;
    pushPlay(pat, l, done_cyc);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    clr     = 1'b0;
    pattern = '0;
    length  = '0;

    vecs[0] = '{pat: 32'h0000_0005, len: 16'd3,  exp_l: 3,  done_cyc: 19};
    vecs[1] = '{pat: 32'hA5A5_0F0F, len: 16'd0,  exp_l: 0,  done_cyc: 1};
    vecs[2] = '{pat: 32'h8000_0001, len: 16'd40, exp_l: 32, done_cyc: 193};
    vecs[3] = '{pat: 32'hDEAD_BEEF, len: 16'd8,  exp_l: 8,  done_cyc: 49};
    vecs[4] = '{pat: 32'h0000_0001, len: 16'd1,  exp_l: 1,  done_cyc: 7};
    vecs[5] = '{pat: 32'h1234_5678, len: 16'd32, exp_l: 32, done_cyc: 193};

    #1;
    checkValue("reset_state", '{v: 1'b0, b: 1'b0, bsy: 1'b0, d: 1'b0});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkValue("after_reset", '{v: 1'b0, b: 1'b0, bsy: 1'b0, d: 1'b0});

    // Table-driven playbacks.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pat, vecs[i].len, vecs[i].exp_l, vecs[i].done_cyc);
      checkOutput($sformatf("vec%0d", i));
      start = 1'b0;
      drain($sformatf("vec%0d", i), exp_q.size());
    end

    // Abort with clr during the second bit's gap (cycle 11).
    applyStimulus(32'h0000_0005, 16'd3, 3, 19);
    checkOutput("clr_play");
    start = 1'b0;
    drain("clr_play", 10);
    exp_q.delete();
    pushIdle(9);
    clr = 1'b1;
    checkOutput("clr_abort");
    clr = 1'b0;
    drain("clr_after", 8);

    // start while busy with a new pattern: ignored, original keeps playing.
    applyStimulus(32'h0000_0005, 16'd3, 3, 19);
    checkOutput("ignore_play");
    start = 1'b0;
    drain("ignore_play", 2);
    pattern = 32'hFFFF_FFFF;
    length  = 16'd5;
    start   = 1'b1;
    checkOutput("ignore_start");
    start   = 1'b0;
    drain("ignore_play", exp_q.size());

    // start held high: next playback one cycle after done.
    pattern = 32'h0000_0001;
    length  = 16'd1;
    start   = 1'b1;
    pushPlay(32'h0000_0001, 1, 7);
    pushPlay(32'h0000_0001, 1, 7);
    pushIdle(1);
    drain("b2b", 10);
    start = 1'b0;
    drain("b2b", exp_q.size());

    // Asynchronous reset mid-SHOW.
    applyStimulus(32'h0000_0005, 16'd3, 3, 19);
    checkOutput("rst_play");
    start = 1'b0;
    checkOutput("rst_play");
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checkValue("rst_async", '{v: 1'b0, b: 1'b0, bsy: 1'b0, d: 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushIdle(5);
    drain("rst_after", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
